// File: rtl/maple_pkg.sv
// Shared types and protocol constants for the Maple bus receive path.
package maple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END
  } state_e;

  localparam int START_B_PULSES = 4;
  localparam int END_A_PULSES   = 2;
  localparam int BYTE_BITS      = 8;
  localparam int BIT_W          = $clog2(BYTE_BITS);

  typedef logic [2:0] pulse_cnt_t;

  // Saturating so a long run of stray pulses can never wrap back onto a legal count.
  function automatic pulse_cnt_t pulse_inc(input pulse_cnt_t c);
    return (c == '1) ? c : c + 3'd1;
  endfunction

endpackage

// File: rtl/maple_line_sync.sv
// Pin synchronizer for one Maple line with registered level and rise/fall strobes.
module maple_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the chain resets to 1 (bus idles high) so leaving reset never fakes a falling edge.
      r_sync  <= '1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value, one stage per clock.
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_level <= w_sync;
      r_rise  <= ~r_level & w_sync;
      r_fall  <= r_level & ~w_sync;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/maple_rx_deframer.sv
// Maple bus receive deframer: decodes start/data/end patterns into an 8-bit AXI-Stream master.
module maple_rx_deframer
  import maple_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       sdcka_in,
  input  logic       sdckb_in,
  input  logic       enable,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tstrb,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic       receiving,
  output logic       frame_error,
  output logic       overrun
);

  logic w_a_lvl, w_a_rise, w_a_fall;
  logic w_b_lvl, w_b_rise, w_b_fall;

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_pin   (sdcka_in),
    .o_level (w_a_lvl),
    .o_rise  (w_a_rise),
    .o_fall  (w_a_fall)
  );

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_pin   (sdckb_in),
    .o_level (w_b_lvl),
    .o_rise  (w_b_rise),
    .o_fall  (w_b_fall)
  );

  state_e               r_state;
  pulse_cnt_t           r_pcnt;
  logic [BIT_W-1:0]     r_bit;
  logic [BYTE_BITS-2:0] r_shift;
  logic [7:0]           r_hold;
  logic                 r_hold_full;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_frame_error;
  logic                 r_tvalid;
  logic [7:0]           r_tdata;
  logic                 r_tlast;
  logic                 r_overrun;

  logic w_active, w_any_edge, w_both_fall, w_to_hit, w_ok;
  logic w_push_mid, w_push_end, w_push;

  assign w_active    = (r_state != ST_IDLE);
  assign w_any_edge  = w_a_rise | w_a_fall | w_b_rise | w_b_fall;
  assign w_both_fall = w_a_fall & w_b_fall;
  assign w_to_hit    = w_active && !w_any_edge && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_ok        = w_active && enable && !w_both_fall && !w_to_hit;

  // The held byte leaves either when the next byte starts (not last) or on a clean end pattern (last).
  assign w_push_mid = w_ok && (r_state == ST_DATA) && w_a_fall && (r_bit == '0) && r_hold_full;
  assign w_push_end = w_ok && (r_state == ST_END) && w_b_rise &&
                      (r_pcnt == pulse_cnt_t'(END_A_PULSES)) && r_hold_full;
  assign w_push     = w_push_mid | w_push_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_to_cnt <= '0;
    end else if (!w_active || w_any_edge) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_pcnt        <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (enable && w_a_fall && w_b_lvl) begin
          r_state <= ST_START;
          r_pcnt  <= '0;
        end
      end else if (!enable) begin
        r_state     <= ST_IDLE;
        r_hold_full <= 1'b0;
      end else if (w_both_fall || w_to_hit) begin
        r_frame_error <= 1'b1;
        r_state       <= ST_IDLE;
        r_hold_full   <= 1'b0;
      end else begin
        case (r_state)
          ST_START: begin
            if (w_b_fall) r_pcnt <= pulse_inc(r_pcnt);
            if (w_a_rise) begin
              if (r_pcnt == pulse_cnt_t'(START_B_PULSES)) begin
                r_state <= ST_DATA;
                r_bit   <= '0;
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            // Even bits are clocked by A (data on B), odd bits by B (data on A).
            if (w_a_fall) begin
              if (r_bit[0]) begin
                r_frame_error <= 1'b1;
                r_state       <= ST_IDLE;
                r_hold_full   <= 1'b0;
              end else begin
                r_shift <= {r_shift[BYTE_BITS-3:0], w_b_lvl};
                r_bit   <= r_bit + BIT_W'(1);
                if (r_bit == '0) r_hold_full <= 1'b0;
              end
            end else if (w_b_fall) begin
              if (r_bit == '0) begin
                if (w_a_lvl) begin
                  r_state <= ST_END;
                  r_pcnt  <= '0;
                end else begin
                  r_frame_error <= 1'b1;
                  r_state       <= ST_IDLE;
                  r_hold_full   <= 1'b0;
                end
              end else if (!r_bit[0]) begin
                r_frame_error <= 1'b1;
                r_state       <= ST_IDLE;
                r_hold_full   <= 1'b0;
              end else if (r_bit == BIT_W'(BYTE_BITS - 1)) begin
                r_hold      <= {r_shift, w_a_lvl};
                r_hold_full <= 1'b1;
                r_bit       <= '0;
              end else begin
                r_shift <= {r_shift[BYTE_BITS-3:0], w_a_lvl};
                r_bit   <= r_bit + BIT_W'(1);
              end
            end
          end
          ST_END: begin
            if (w_a_fall) r_pcnt <= pulse_inc(r_pcnt);
            if (w_b_rise) begin
              r_state     <= ST_IDLE;
              r_hold_full <= 1'b0;
              if (r_pcnt != pulse_cnt_t'(END_A_PULSES)) r_frame_error <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tlast   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_push) begin
      if (!r_tvalid || m_axis_tready) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_hold;
        r_tlast  <= w_push_end;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tstrb  = 1'b1;
  assign m_axis_tlast  = r_tlast;
  assign receiving     = w_active;
  assign frame_error   = r_frame_error;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_maple_rx_deframer.sv
// Directed bench for maple_rx_deframer: drives Maple pin waveforms and checks emitted beats and flags.
module tb_maple_rx_deframer;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int TO_W           = 10;
  localparam int HOLD           = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       sdcka_in = 1'b1;
  logic       sdckb_in = 1'b1;
  logic       enable = 1'b0;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tstrb;
  logic       m_axis_tlast;
  logic       receiving;
  logic       frame_error;
  logic       overrun;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_err_pulses = 0;
  logic [8:0] beats[$];

  maple_rx_deframer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sdcka_in      (sdcka_in),
    .sdckb_in      (sdckb_in),
    .enable        (enable),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .receiving     (receiving),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  always #5 aclk = ~aclk;

  // Beats and error pulses are sampled mid-cycle; inputs only change just after the rising edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
      if (frame_error) n_err_pulses++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [8:0] exp);
    logic [31:0] got;
    got = (beats.size() != 0) ? {23'd0, beats.pop_front()} : 32'hDEAD;
    check(tag, got, {23'd0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_mon();
    beats.delete();
    n_err_pulses = 0;
  endtask

  task automatic drive(input logic a, input logic b);
    @(posedge aclk);
    #2;
    sdcka_in = a;
    sdckb_in = b;
    repeat (HOLD - 1) @(posedge aclk);
  endtask

  // n falls on B while A is low; B is left low after the last fall, then A rises.
  task automatic send_start(input int n);
    drive(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0);
      if (i < n - 1) drive(1'b0, 1'b1);
    end
    drive(1'b1, 1'b0);
  endtask

  // MSB first; each line only ever falls when it is the clock for the current bit.
  task automatic send_bits(input logic [7:0] v, input int n);
    logic d;
    for (int i = 0; i < n; i++) begin
      d = v[7-i];
      if ((i % 2) == 0) begin
        drive(sdcka_in, d);
        if (!sdcka_in) drive(1'b1, d);
        drive(1'b0, d);
      end else begin
        drive(d, sdckb_in);
        if (!sdckb_in) drive(d, 1'b1);
        drive(d, 1'b0);
      end
    end
  endtask

  // B falls with A high, A pulses twice, B rises; lat = cycles from B rise to tvalid.
  task automatic send_end(output int lat);
    drive(1'b1, sdckb_in);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    repeat (2) begin
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
    end
    @(posedge aclk);
    #2;
    sdckb_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge aclk);
      #1;
      if (m_axis_tvalid && lat == 0) lat = k;
    end
  endtask

  initial begin
    int lat;

    // Reset state
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_tstrb", {31'd0, m_axis_tstrb}, 32'd1);
    check("rst_receiving", {31'd0, receiving}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    tick(4);

    // 1: two-byte frame, tready high
    clear_mon();
    send_start(4);
    check("t1_receiving", {31'd0, receiving}, 32'd1);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    send_end(lat);
    check("t1_latency", lat, SYNC_STAGES + 2);
    tick(4);
    check("t1_nbeats", beats.size(), 32'd2);
    check_beat("t1_beat0", {1'b0, 8'hA5});
    check_beat("t1_beat1", {1'b1, 8'h3C});
    check("t1_errors", n_err_pulses, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    check("t1_idle", {31'd0, receiving}, 32'd0);

    // 2: tready low across a three-byte frame
    clear_mon();
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b0;
    send_start(4);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_end(lat);
    tick(4);
    check("t2_tvalid_held", {31'd0, m_axis_tvalid}, 32'd1);
    check("t2_tdata_held", {24'd0, m_axis_tdata}, 32'h11);
    check("t2_tlast_held", {31'd0, m_axis_tlast}, 32'd0);
    check("t2_overrun", {31'd0, overrun}, 32'd1);
    check("t2_no_beats_yet", beats.size(), 32'd0);
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b1;
    tick(4);
    check("t2_tvalid_drop", {31'd0, m_axis_tvalid}, 32'd0);
    check("t2_nbeats", beats.size(), 32'd1);
    check_beat("t2_beat0", {1'b0, 8'h11});
    check("t2_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("t2_errors", n_err_pulses, 32'd0);

    // 3: frame 0x5A frozen after bit 3 until timeout
    clear_mon();
    send_start(4);
    send_bits(8'h5A, 4);
    check("t3_receiving", {31'd0, receiving}, 32'd1);
    lat = 0;
    for (int k = 1; k <= TIMEOUT_CYCLES + 50; k++) begin
      @(posedge aclk);
      #1;
      if (frame_error) begin
        lat = k;
        break;
      end
    end
    // Last fall plus sync/strobe pipeline puts the pulse about 1001 cycles after the drive returns.
    check("t3_timeout_window", {31'd0, (lat >= 998 && lat <= 1004)}, 32'd1);
    tick(5);
    check("t3_error_pulses", n_err_pulses, 32'd1);
    check("t3_no_beat", beats.size(), 32'd0);
    check("t3_idle", {31'd0, receiving}, 32'd0);
    drive(1'b1, 1'b1);

    // 4: short start pattern, then a clean frame
    clear_mon();
    send_start(3);
    tick(4);
    check("t4_error_pulses", n_err_pulses, 32'd1);
    check("t4_idle", {31'd0, receiving}, 32'd0);
    drive(1'b1, 1'b1);
    clear_mon();
    send_start(4);
    send_bits(8'h81, 8);
    send_end(lat);
    tick(4);
    check("t4_nbeats", beats.size(), 32'd1);
    check_beat("t4_beat0", {1'b1, 8'h81});
    check("t4_errors_after", n_err_pulses, 32'd0);

    // 5: reset during bit 5 of byte 2 with a beat pending
    clear_mon();
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b0;
    send_start(4);
    send_bits(8'h12, 8);
    send_bits(8'h34, 5);
    check("t5_pending_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t5_pending_data", {24'd0, m_axis_tdata}, 32'h12);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    sdcka_in = 1'b1;
    sdckb_in = 1'b1;
    #1;
    check("t5_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t5_rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("t5_rst_receiving", {31'd0, receiving}, 32'd0);
    check("t5_rst_overrun", {31'd0, overrun}, 32'd0);
    tick(3);
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    tick(4);
    clear_mon();
    send_start(4);
    send_bits(8'hFF, 8);
    send_bits(8'h00, 8);
    send_end(lat);
    tick(4);
    check("t5_nbeats", beats.size(), 32'd2);
    check_beat("t5_beat0", {1'b0, 8'hFF});
    check_beat("t5_beat1", {1'b1, 8'h00});
    check("t5_errors", n_err_pulses, 32'd0);

    // 6: zero-byte frame, then enable dropped mid-frame
    clear_mon();
    send_start(4);
    send_end(lat);
    tick(4);
    check("t6_zero_nbeats", beats.size(), 32'd0);
    check("t6_zero_errors", n_err_pulses, 32'd0);
    check("t6_zero_idle", {31'd0, receiving}, 32'd0);
    send_start(4);
    send_bits(8'h77, 8);
    check("t6_abort_busy", {31'd0, receiving}, 32'd1);
    @(posedge aclk);
    #2;
    enable = 1'b0;
    tick(3);
    check("t6_abort_idle", {31'd0, receiving}, 32'd0);
    drive(1'b1, 1'b1);
    tick(4);
    check("t6_abort_nbeats", beats.size(), 32'd0);
    check("t6_abort_errors", n_err_pulses, 32'd0);
    @(posedge aclk);
    #2;
    enable = 1'b1;
    send_start(4);
    send_bits(8'h42, 8);
    send_end(lat);
    tick(4);
    check_beat("t6_recover_beat", {1'b1, 8'h42});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
